md_sequencer: RTL

//   Sequences the iterative multiply/divide resource and owns the HI/LO registers.

---
 rtl/md_sequencer_if.sv | 25 ++
 rtl/md_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/md_sequencer_if.sv
// EX/ID-side handshake and HI/LO read-out bundle for the multiply/divide sequencer.
// The master drives operations in; the slave (sequencer) reports busy/stall/results.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_in_id;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    modport master (
        output start, op, flush, rs_data, rt_data, md_in_id,
        input  busy, md_stall, hi, lo, done
    );

    modport slave (
        input  start, op, flush, rs_data, rt_data, md_in_id,
        output busy, md_stall, hi, lo, done
    );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide sequencer that owns HI/LO and raises MultBusy/stall.
// Results are formed from latched operands and committed on the final busy cycle.
module md_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic        uns_q, done_q;
    logic        accept;
    logic [63:0] mul_res, div_res;

    function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic uns);
        logic signed [63:0] sa, sb, sp;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        if (uns) return {32'd0, a} * {32'd0, b};
        return $unsigned(sp);
    endfunction

    // Returns {remainder, quotient}; the INT_MIN / -1 case is pinned so the quotient wraps cleanly.
    function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic uns);
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (uns) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $unsigned(sa / sb);
            r = $unsigned(sa % sb);
        end
        return {r, q};
    endfunction

    assign mul_res = mul_full(a_q, b_q, uns_q);
    assign div_res = div_full(a_q, b_q, uns_q);

    always_comb begin
        state_d = state_q;
        accept  = md.start & ~md.flush & (state_q == IDLE) & (md.op <= 3'd5);
        case (state_q)
            IDLE: begin
                if (accept && md.op[2:1] == 2'b00) state_d = MUL;
                else if (accept && md.op[2:1] == 2'b01) state_d = DIV;
            end
            MUL, DIV: begin
                if (cnt_q == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            uns_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                case (md.op)
                    3'd0, 3'd1: begin
                        cnt_q <= 4'(MUL_CYCLES - 1);
                        a_q   <= md.rs_data;
                        b_q   <= md.rt_data;
                        uns_q <= md.op[0];
                    end
                    3'd2, 3'd3: begin
                        cnt_q <= 4'(DIV_CYCLES - 1);
                        a_q   <= md.rs_data;
                        b_q   <= md.rt_data;
                        uns_q <= md.op[0];
                    end
                    3'd4:    hi_q <= md.rs_data;
                    default: lo_q <= md.rs_data;
                endcase
            end else if (state_q != IDLE) begin
                // Final busy cycle: commit now so the result appears together with done.
                if (cnt_q == 4'd0) begin
                    done_q <= 1'b1;
                    if (state_q == MUL) begin
                        {hi_q, lo_q} <= mul_res;
                    end else if (b_q != 32'd0) begin
                        {hi_q, lo_q} <= div_res;
                    end
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

    assign md.busy     = (state_q != IDLE);
    assign md.md_stall = md.md_in_id & ((state_q != IDLE) | accept);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.done     = done_q;
endmodule
